board_renderer: RTL

Downstream consumer of the game-board RAM. On a start pulse it takes the memory-mux VGA port, reads all 64 board cells in address order, and plots each cell as an 8×8 pixel square into the VGA adapter. A one-cell cursor outline is overlaid. It also produces black and white piece counts for the score display and end-of-game logic. It runs after the main controller finishes a move: after init_done, or after nm_done with ack.

---
 rtl/othello_pkg.sv | 40 ++++
 rtl/cell_palette.sv | 23 ++
 rtl/board_renderer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/othello_pkg.sv
// Shared board/palette definitions for the Othello display path.
package othello_pkg;

    // Cell encoding as stored in the game-board RAM
    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] BLACK    = 2'b01;
    localparam logic [1:0] WHITE    = 2'b10;
    localparam logic [1:0] RESERVED = 2'b11;

    // RGB palette
    localparam logic [2:0] PAL_EMPTY    = 3'b010;
    localparam logic [2:0] PAL_BLACK    = 3'b000;
    localparam logic [2:0] PAL_WHITE    = 3'b111;
    localparam logic [2:0] PAL_RESERVED = 3'b100;
    localparam logic [2:0] PAL_CURSOR   = 3'b110;

    localparam int BOARD_DIM = 8;
    localparam int CELL_PX   = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_DRAW = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Fill colour of a cell, ignoring the cursor outline
    function automatic logic [2:0] cell_colour(input logic [1:0] v);
        logic [2:0] c;
        case (v)
            EMPTY:   c = PAL_EMPTY;
            BLACK:   c = PAL_BLACK;
            WHITE:   c = PAL_WHITE;
            default: c = PAL_RESERVED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cell_palette.sv
// Per-pixel colour of one board square, with the cursor outline overlaid
// on the square's border ring.
import othello_pkg::*;

module cell_palette (
    input  logic [1:0] i_cell,
    input  logic       i_is_cursor,
    input  logic [2:0] i_px,
    input  logic [2:0] i_py,
    output logic [2:0] o_colour
);
    logic w_border;

    // Border ring of the 8x8 square gets the cursor colour, interior keeps fill
    always_comb begin
        w_border = (i_px == 3'd0) || (i_px == 3'd7) || (i_py == 3'd0) || (i_py == 3'd7);
        if (i_is_cursor && w_border)
            o_colour = PAL_CURSOR;
        else
            o_colour = cell_colour(i_cell);
    end

endmodule

// File: rtl/board_renderer.sv
// Walks the 64 board cells in address order, reads each from RAM and
// plots it as an 8x8 square; tallies black/white pieces on the way.
// Every output is a register, so pixel values are computed from the
// next-state view of the datapath one edge ahead of the plot cycle.
import othello_pkg::*;

module board_renderer #(
    parameter int X0 = 48,
    parameter int Y0 = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] cursor_in,
    input  logic [1:0] data_in,
    output logic       ctrl_mem,
    output logic [6:0] addr_out,
    output logic       wren_o,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [6:0] black_count,
    output logic [6:0] white_count
);
    state_t     r_state, w_state_nxt;
    logic [5:0] r_cell, w_cell_nxt;
    logic [5:0] r_pix, w_pix_nxt;
    logic [1:0] r_val, w_val_nxt;
    logic [6:0] r_cursor;
    logic [6:0] r_black, r_white;

    logic       r_ctrl, r_busy, r_done, r_plot;
    logic [6:0] r_addr;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;

    logic       w_last_pix, w_last_cell, w_active_nxt, w_is_cursor;
    logic [7:0] w_x_nxt;
    logic [6:0] w_y_nxt;
    logic [2:0] w_colour_nxt;

    assign w_last_pix  = (r_pix == 6'd63);
    assign w_last_cell = (r_cell == 6'd63);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_DRAW;
            S_DRAW:  if (w_last_pix) w_state_nxt = w_last_cell ? S_DONE : S_READ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next values and the pixel that the next cycle will plot
    always_comb begin
        w_cell_nxt = r_cell;
        w_pix_nxt  = r_pix;
        w_val_nxt  = r_val;
        case (r_state)
            S_IDLE: if (start) w_cell_nxt = 6'd0;
            S_WAIT: begin
                w_val_nxt = data_in;
                w_pix_nxt = 6'd0;
            end
            S_DRAW: begin
                w_pix_nxt = r_pix + 6'd1;
                if (w_last_pix && !w_last_cell) w_cell_nxt = r_cell + 6'd1;
            end
            default: ;
        endcase
        w_active_nxt = (w_state_nxt == S_READ) || (w_state_nxt == S_WAIT) ||
                       (w_state_nxt == S_DRAW);
        w_is_cursor  = !r_cursor[6] && (r_cursor[5:0] == r_cell);
        w_x_nxt      = 8'(X0) + {2'b00, r_cell[2:0], w_pix_nxt[2:0]};
        w_y_nxt      = 7'(Y0) + {1'b0, r_cell[5:3], w_pix_nxt[5:3]};
    end

    cell_palette u_palette (
        .i_cell      (w_val_nxt),
        .i_is_cursor (w_is_cursor),
        .i_px        (w_pix_nxt[2:0]),
        .i_py        (w_pix_nxt[5:3]),
        .o_colour    (w_colour_nxt)
    );

    // Cell walk, latched cursor and piece counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cell   <= '0;
            r_pix    <= '0;
            r_val    <= '0;
            r_cursor <= '0;
            r_black  <= '0;
            r_white  <= '0;
        end else begin
            r_cell <= w_cell_nxt;
            r_pix  <= w_pix_nxt;
            r_val  <= w_val_nxt;
            if (r_state == S_IDLE && start) begin
                r_cursor <= cursor_in;
                r_black  <= '0;
                r_white  <= '0;
            end
            if (r_state == S_WAIT) begin
                if (data_in == BLACK) r_black <= r_black + 7'd1;
                if (data_in == WHITE) r_white <= r_white + 7'd1;
            end
        end
    end

    // Registered outputs; pixel coordinates and colour hold between plots
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_addr   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_ctrl <= w_active_nxt;
            r_busy <= w_active_nxt;
            r_done <= (w_state_nxt == S_DONE);
            r_plot <= (w_state_nxt == S_DRAW);
            if (w_state_nxt == S_READ) r_addr <= {1'b0, w_cell_nxt};
            if (w_state_nxt == S_DRAW) begin
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_colour <= w_colour_nxt;
            end
        end
    end

    assign ctrl_mem    = r_ctrl;
    assign busy        = r_busy;
    assign done        = r_done;
    assign plot        = r_plot;
    assign addr_out    = r_addr;
    assign wren_o      = 1'b0;
    assign x           = r_x;
    assign y           = r_y;
    assign colour      = r_colour;
    assign black_count = r_black;
    assign white_count = r_white;

endmodule
